// File: rtl/im2_int_responder.sv
// Z80 mode-2 interrupt responder.
// Collects peripheral interrupt requests, drives /INT, answers the interrupt-acknowledge
// cycle with a vector byte, and releases in-service sources on a decoded RETI (ED 4D).
//
// Ports:
//   clkcpu  - CPU clock, all state on rising edge
//   rst_n   - asynchronous active-low reset
//   irq_in  - level requests from peripherals (rising edge requests service)
//   m1, mreq, iorq, rd, wr, rfsh - decoded active-high CPU bus strobes
//   a       - CPU address bus
//   d_in    - CPU data bus as observed
//   d_out   - byte driven onto the data bus
//   d_oe    - data bus drive enable
//   n_int   - interrupt request to the CPU, active-low
//   busy    - high while any source is in service
module im2_int_responder #(
  parameter int unsigned SOURCES     = 4,
  parameter logic [7:0]  VECTOR_BASE = 8'hF0,
  parameter logic [7:0]  PORT_LO     = 8'hDF
) (
  input  logic               clkcpu,
  input  logic               rst_n,
  input  logic [SOURCES-1:0] irq_in,
  input  logic               m1,
  input  logic               mreq,
  input  logic               iorq,
  input  logic               rd,
  input  logic               wr,
  input  logic               rfsh,
  input  logic [15:0]        a,
  input  logic [7:0]         d_in,
  output logic [7:0]         d_out,
  output logic               d_oe,
  output logic               n_int,
  output logic               busy
);

  typedef enum logic [0:0] {StIdle, StGotEd} reti_e;

  logic [SOURCES-1:0] enable_q;
  logic [SOURCES-1:0] pending_q, pending_d;
  logic [SOURCES-1:0] in_service_q, in_service_d;
  logic [SOURCES-1:0] irq_prev_q;
  logic               n_int_q;
  logic               busy_q;
  logic               ack_q;
  logic               ack_spur_q;
  logic [1:0]         ack_idx_q;
  logic [7:0]         ack_vec_q;
  logic               fetch_q;
  logic [7:0]         op_q;
  reti_e              reti_q, reti_d;

  logic               ack_cyc, ack_start, ack_end;
  logic               port_hit, ctl_wr, st_rd;
  logic               fetch, commit, release_is;
  logic [SOURCES-1:0] rise;
  logic [1:0]         win, hi_is;
  logic               is_none, request_ok;
  logic [3:0]         is4, pend4;
  logic               unused_bits;

  assign unused_bits = ^{a[15:8], d_in};

  // Bus decode
  always_comb begin
    ack_cyc   = m1 & iorq;
    ack_start = ack_cyc & ~ack_q;
    ack_end   = ack_q & ~ack_cyc;
    port_hit  = iorq & ~m1 & (a[7:0] == PORT_LO);
    ctl_wr    = port_hit & wr;
    st_rd     = port_hit & rd;
    fetch     = m1 & mreq & rd & ~rfsh;
    commit    = fetch_q & ~fetch;
    rise      = irq_in & ~irq_prev_q;
  end

  // Priority: lowest index wins; hi_is is the highest-priority source in service
  always_comb begin
    win     = 2'd0;
    hi_is   = 2'd0;
    is_none = 1'b1;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      if (pending_q[i]) win = 2'(i);
      if (in_service_q[i]) begin
        hi_is   = 2'(i);
        is_none = 1'b0;
      end
    end
    request_ok = (|pending_q) && (is_none || (win < hi_is));
  end

  // RETI detector and pending/in-service next state
  always_comb begin
    reti_d       = reti_q;
    release_is   = 1'b0;
    pending_d    = pending_q;
    in_service_d = in_service_q;

    if (commit) begin
      unique case (reti_q)
        StIdle: begin
          if (op_q == 8'hED) reti_d = StGotEd;
        end
        StGotEd: begin
          if (op_q == 8'h4D) begin
            release_is = 1'b1;
            reti_d     = StIdle;
          end else if (op_q != 8'hED) begin
            reti_d = StIdle;
          end
        end
      endcase
    end

    for (int i = 0; i < SOURCES; i++) begin
      if (release_is && !is_none && (hi_is == 2'(i))) in_service_d[i] = 1'b0;
      if (ack_end && !ack_spur_q && (ack_idx_q == 2'(i))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
    end

    // A new edge on the acknowledged source re-pends it (set wins over ack clear)
    pending_d = pending_d | (rise & enable_q);
    if (ctl_wr) pending_d = pending_d & d_in[SOURCES-1:0];
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_prev_q   <= '0;
      n_int_q      <= 1'b1;
      busy_q       <= 1'b0;
      ack_q        <= 1'b0;
      ack_spur_q   <= 1'b0;
      ack_idx_q    <= 2'd0;
      ack_vec_q    <= 8'h00;
      fetch_q      <= 1'b0;
      op_q         <= 8'h00;
      reti_q       <= StIdle;
    end else begin
      if (ctl_wr) enable_q <= d_in[SOURCES-1:0];
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_prev_q   <= irq_in;
      n_int_q      <= ~request_ok;
      busy_q       <= |in_service_d;
      reti_q       <= reti_d;
      fetch_q      <= fetch;
      if (fetch) op_q <= d_in;

      if (ack_start) begin
        ack_q      <= 1'b1;
        ack_idx_q  <= win;
        ack_spur_q <= ~request_ok;
        ack_vec_q  <= request_ok ? {VECTOR_BASE[7:3], win, 1'b0} : {VECTOR_BASE[7:3], 3'b111};
      end else if (ack_end) begin
        ack_q <= 1'b0;
      end
    end
  end

  // Outputs: status read is combinational from registers
  always_comb begin
    is4                  = 4'h0;
    pend4                = 4'h0;
    is4[SOURCES-1:0]     = in_service_q;
    pend4[SOURCES-1:0]   = pending_q;
    d_oe                 = st_rd | ack_q;
    d_out                = 8'h00;
    if (st_rd) d_out = {is4, pend4};
    else if (ack_q) d_out = ack_vec_q;
    n_int = n_int_q;
    busy  = busy_q;
  end

endmodule

// File: tb/tb_im2_int_responder.sv
// Table-driven bench for im2_int_responder: each row is one clock cycle of bus activity
// with the outputs expected just after that cycle's rising edge.
module tb_im2_int_responder;

  logic        clkcpu = 1'b0;
  logic        rst_n;
  logic [3:0]  irq_in;
  logic        m1, mreq, iorq, rd, wr, rfsh;
  logic [15:0] a;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe, n_int, busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {OpIdle, OpWr, OpRd, OpAck, OpFetch} op_e;

  typedef struct {
    string      name;
    op_e        op;
    logic [7:0] data;
    logic [3:0] irq;
    logic       doe;
    logic [7:0] dout;
    logic       nint;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clkcpu = ~clkcpu;

  im2_int_responder #(
    .SOURCES    (4),
    .VECTOR_BASE(8'hF0),
    .PORT_LO    (8'hDF)
  ) dut (
    .clkcpu(clkcpu),
    .rst_n (rst_n),
    .irq_in(irq_in),
    .m1    (m1),
    .mreq  (mreq),
    .iorq  (iorq),
    .rd    (rd),
    .wr    (wr),
    .rfsh  (rfsh),
    .a     (a),
    .d_in  (d_in),
    .d_out (d_out),
    .d_oe  (d_oe),
    .n_int (n_int),
    .busy  (busy)
  );

  function automatic void add(input string name, input op_e op, input logic [7:0] data,
                              input logic [3:0] irq, input logic doe, input logic [7:0] dout,
                              input logic nint, input logic bsy);
    vec_t v;
    v.name = name; v.op = op; v.data = data; v.irq = irq;
    v.doe = doe; v.dout = dout; v.nint = nint; v.busy = bsy;
    tbl.push_back(v);
  endfunction

  task automatic drive(input op_e op, input logic [7:0] data, input logic [3:0] irq);
    m1 = 0; mreq = 0; iorq = 0; rd = 0; wr = 0; rfsh = 0;
    a = 16'h0000; d_in = 8'h00; irq_in = irq;
    case (op)
      OpWr:    begin iorq = 1; wr = 1; a = 16'h12DF; d_in = data; end
      OpRd:    begin iorq = 1; rd = 1; a = 16'h34DF; end
      OpAck:   begin m1 = 1; iorq = 1; end
      OpFetch: begin m1 = 1; mreq = 1; rd = 1; a = 16'h0100; d_in = data; end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic doe, input logic [7:0] dout,
                       input logic nint, input logic bsy);
    n_checks++;
    if (d_oe !== doe || d_out !== dout || n_int !== nint || busy !== bsy) begin
      n_fail++;
      $display("FAIL %s: got d_oe=%b d_out=%h n_int=%b busy=%b, want d_oe=%b d_out=%h n_int=%b busy=%b",
               name, d_oe, d_out, n_int, busy, doe, dout, nint, bsy);
    end
  endtask

  task automatic step(input vec_t v);
    drive(v.op, v.data, v.irq);
    @(posedge clkcpu);
    #1;
    check(v.name, v.doe, v.dout, v.nint, v.busy);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    drive(OpIdle, 8'h00, 4'h0);

    // name, op, data, irq, d_oe, d_out, n_int, busy
    add("wr_en03",      OpWr,    8'h03, 4'h0, 0, 8'h00, 1, 0);
    add("irq1_rise",    OpIdle,  8'h00, 4'h2, 0, 8'h00, 1, 0);
    add("irq1_nint",    OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 0);
    add("status_02",    OpRd,    8'h00, 4'h0, 1, 8'h02, 0, 0);
    add("ack1_a",       OpAck,   8'h00, 4'h0, 1, 8'hF2, 0, 0);
    add("ack1_b",       OpAck,   8'h00, 4'h0, 1, 8'hF2, 0, 0);
    add("ack1_end",     OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 1);
    add("ack1_nint_hi", OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("status_20",    OpRd,    8'h00, 4'h0, 1, 8'h20, 1, 1);
    add("irq0_rise",    OpIdle,  8'h00, 4'h1, 0, 8'h00, 1, 1);
    add("irq0_nest",    OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 1);
    add("ack0",         OpAck,   8'h00, 4'h0, 1, 8'hF0, 0, 1);
    add("ack0_end",     OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 1);
    add("ack0_nint_hi", OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("irq1_again",   OpIdle,  8'h00, 4'h2, 0, 8'h00, 1, 1);
    add("irq1_blocked", OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("status_32",    OpRd,    8'h00, 4'h0, 1, 8'h32, 1, 1);
    add("f_ed_1",       OpFetch, 8'hED, 4'h0, 0, 8'h00, 1, 1);
    add("c_ed_1",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_4d_1",       OpFetch, 8'h4D, 4'h0, 0, 8'h00, 1, 1);
    add("c_4d_1",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("status_22",    OpRd,    8'h00, 4'h0, 1, 8'h22, 1, 1);
    add("f_ed_2",       OpFetch, 8'hED, 4'h0, 0, 8'h00, 1, 1);
    add("c_ed_2",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_4d_2",       OpFetch, 8'h4D, 4'h0, 0, 8'h00, 1, 1);
    add("c_4d_2_idle",  OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 0);
    add("pend1_unblk",  OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 0);
    add("ack1_again",   OpAck,   8'h00, 4'h0, 1, 8'hF2, 0, 0);
    add("ack1_again_e", OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 1);
    add("ack1_again_n", OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_ed_retn",    OpFetch, 8'hED, 4'h0, 0, 8'h00, 1, 1);
    add("c_ed_retn",    OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_45_retn",    OpFetch, 8'h45, 4'h0, 0, 8'h00, 1, 1);
    add("c_45_retn",    OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("status_retn",  OpRd,    8'h00, 4'h0, 1, 8'h20, 1, 1);
    add("f_ed_a",       OpFetch, 8'hED, 4'h0, 0, 8'h00, 1, 1);
    add("c_ed_a",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_ed_b",       OpFetch, 8'hED, 4'h0, 0, 8'h00, 1, 1);
    add("c_ed_b",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 1);
    add("f_4d_c",       OpFetch, 8'h4D, 4'h0, 0, 8'h00, 1, 1);
    add("c_4d_c",       OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 0);
    add("status_00",    OpRd,    8'h00, 4'h0, 1, 8'h00, 1, 0);
    add("irq0_p",       OpIdle,  8'h00, 4'h1, 0, 8'h00, 1, 0);
    add("irq0_p_nint",  OpIdle,  8'h00, 4'h0, 0, 8'h00, 0, 0);
    add("wr_en00",      OpWr,    8'h00, 4'h0, 0, 8'h00, 0, 0);
    add("en00_nint_hi", OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 0);
    add("irq2_disabl",  OpIdle,  8'h00, 4'h4, 0, 8'h00, 1, 0);
    add("irq2_low",     OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 0);
    add("status_dis",   OpRd,    8'h00, 4'h0, 1, 8'h00, 1, 0);
    add("spur_ack",     OpAck,   8'h00, 4'h0, 1, 8'hF7, 1, 0);
    add("spur_end",     OpIdle,  8'h00, 4'h0, 0, 8'h00, 1, 0);
    add("status_spur",  OpRd,    8'h00, 4'h0, 1, 8'h00, 1, 0);

    repeat (3) @(posedge clkcpu);
    #1;
    check("reset_state", 0, 8'h00, 1, 0);
    @(negedge clkcpu);
    rst_n = 1'b1;

    foreach (tbl[i]) step(tbl[i]);

    // Reset asserted mid-acknowledge drops d_oe at once and clears all state
    v.name = "en0f";   v.op = OpWr;   v.data = 8'h0F; v.irq = 4'h0;
    v.doe = 0; v.dout = 8'h00; v.nint = 1; v.busy = 0; step(v);
    v.name = "irq3";   v.op = OpIdle; v.irq = 4'h8; step(v);
    v.name = "irq3_n"; v.irq = 4'h0; v.nint = 0; step(v);
    v.name = "ack3";   v.op = OpAck;  v.doe = 1; v.dout = 8'hF6; step(v);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", 0, 8'h00, 1, 0);
    drive(OpIdle, 8'h00, 4'h0);
    @(negedge clkcpu);
    rst_n = 1'b1;
    v.name = "post_rst_status"; v.op = OpRd; v.doe = 1; v.dout = 8'h00; v.nint = 1; step(v);
    v.name = "post_rst_irq"; v.op = OpIdle; v.irq = 4'h1; v.doe = 0; step(v);
    v.name = "post_rst_dis"; v.irq = 4'h0; step(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im2_int_responder.md
Name: im2_int_responder

Overview:
- Z80 mode-2 interrupt responder. Collects peripheral interrupt requests, drives the CPU /INT line, and answers the CPU's interrupt-acknowledge cycle with a vector byte on the data bus.
- Tracks in-service sources and releases them on a decoded RETI (ED 4D) opcode fetch, which gives nested priority handling.
- Runs on the CPU clock, alongside the frame-interrupt generator. Its n_int output is wire-ANDed with the frame interrupt at the top level.

Parameters:
- SOURCES, 4, number of request inputs (1..4). Index 0 has the highest priority.
- VECTOR_BASE, 8'hF0, base vector byte. Bits [2:0] of the base are ignored.
- PORT_LO, 8'hDF, I/O port low address byte for the control/status register.

Ports:
- clkcpu  input  1  CPU clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- irq_in  input  SOURCES  level requests from peripherals; a rising edge requests service.
- m1  input  1  CPU M1 active (active-high, decoded).
- mreq  input  1  CPU MREQ active.
- iorq  input  1  CPU IORQ active.
- rd  input  1  CPU RD active.
- wr  input  1  CPU WR active.
- rfsh  input  1  CPU refresh cycle active.
- a  input  16  CPU address bus.
- d_in  input  8  CPU data bus, as observed by this block.
- d_out  output  8  byte this block drives onto the data bus.
- d_oe  output  1  data bus drive enable.
- n_int  output  1  interrupt request to the CPU, active-low.
- busy  output  1  high while any source is in service.

Behaviour:
- Reset (async) sets: enable=0, pending=0, in_service=0, prev irq_in=0, RETI FSM=IDLE, n_int=1, d_oe=0, d_out=0, busy=0. d_oe drops immediately, including mid-acknowledge.
- Request capture: irq_in is registered once. A rising edge on bit i with enable[i]=1 sets pending[i]. Requests with enable[i]=0 are dropped, not queued.
- Control write (iorq & wr & !m1 & a[7:0]==PORT_LO): enable <= d_in[SOURCES-1:0].
  - Any bit written 0 also clears its pending bit on the same edge.
  - in_service is unaffected by the write.
- Status read (iorq & rd & !m1 & a[7:0]==PORT_LO): d_oe=1, d_out={in_service padded to 4 bits, pending padded to 4 bits}. This path is combinational from registers.
- Winner selection:
  - win = lowest-index set bit of pending.
  - hi_is = lowest-index set bit of in_service; hi_is is "none" when in_service is empty.
  - request_ok = pending nonzero AND (in_service empty OR win < hi_is).
- n_int is registered: n_int <= !request_ok, so it asserts one clkcpu cycle after pending sets. It deasserts one cycle after the ack clears pending, or once a higher-priority source enters service.
- Acknowledge (m1 & iorq):
  - On the first clkcpu edge of the ack, latch ack_idx=win, set d_out = VECTOR_BASE[7:3], ack_idx[1:0], 0, and set d_oe=1.
  - d_oe holds while m1 & iorq stays active and falls on the first edge after iorq deasserts.
  - On that same edge: pending[ack_idx] <= 0 and in_service[ack_idx] <= 1.
  - If a new rising edge on irq_in[ack_idx] arrives on that edge, set wins: pending stays 1.
  - If no request_ok existed at ack start (spurious ack), drive VECTOR_BASE with bits [2:0]=3'b111 and change no state.
- Opcode fetch capture:
  - fetch = m1 & mreq & rd & !rfsh.
  - d_in is latched on every edge while fetch is active.
  - The byte is committed on the first edge with fetch=0 after fetch=1.
- RETI FSM, advanced on each committed byte:
  - IDLE: byte ED -> GOT_ED; any other byte -> IDLE.
  - GOT_ED: byte 4D -> clear in_service[hi_is] (no-op if empty), go to IDLE. Byte ED -> stay in GOT_ED. Any other byte -> IDLE.
  - RETN (ED 45) and other ED xx bytes release nothing.
- busy = |in_service, registered.
- Unused high bits (SOURCES<4) always read as 0.

Test Plan:
- Reset, then write 0x03 to port xxDF, then pulse irq_in[1] -> pending=0x2; n_int=0 one clkcpu cycle later; status read returns 0x02.
- Ack cycle with VECTOR_BASE=F0 and source 1 pending -> d_oe=1, d_out=0xF2 throughout the ack. After iorq falls: pending=0, in_service=0x2, n_int=1, busy=1.
- Source 1 in service, then pulse irq_in[0] (enabled) -> n_int=0. Ack yields 0xF0 and in_service becomes 0x3. Then pulse irq_in[1] -> n_int stays 1 (1 is not less than 0).
- Fetch sequence ED, 4D with in_service=0x3 -> in_service=0x2. Second ED, 4D -> 0x0, busy=0. Fetch ED, 45 -> no change. Fetch ED, ED, 4D -> release.
- Write enable=0x00 while pending=0x1 -> pending=0, n_int=1 the next cycle. Edge on a disabled source -> no pending.
- Assert rst_n=0 mid-ack with d_oe=1 -> d_oe=0 immediately, all state cleared, n_int=1.
